// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button front end, run/lap/pause FSM and the two-digit BCD
// seconds counter with a lap latch feeding the display decoder.
module stopwatch_ctrl #(
  parameter int unsigned MAX_T = 5  // terminal tens digit; count wraps at MAX_T9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       tick,
  output logic [3:0] disp_u,
  output logic [3:0] disp_t,
  output logic       running,
  output logic       lap_hold,
  output logic       wrap
);

  typedef enum logic [1:0] {StIdle, StRun, StLap, StPause} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_u_q, cnt_u_d, cnt_t_q, cnt_t_d;
  logic [3:0] lap_u_q, lap_u_d, lap_t_q, lap_t_d;
  logic       wrap_q, wrap_d;

  // Two-flop synchronizers plus one delay flop each for edge detection.
  logic [1:0] ss_sync_q, lr_sync_q;
  logic       ss_prev_q, lr_prev_q;
  logic       ss_p, lr_p;
  logic       counting, at_max;

  // Button synchronizers and edge-detect history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ss_sync_q <= 2'b00;
      lr_sync_q <= 2'b00;
      ss_prev_q <= 1'b0;
      lr_prev_q <= 1'b0;
    end else begin
      ss_sync_q <= {ss_sync_q[0], btn_ss};
      lr_sync_q <= {lr_sync_q[0], btn_lr};
      ss_prev_q <= ss_sync_q[1];
      lr_prev_q <= lr_sync_q[1];
    end
  end

  // Next-state logic for FSM, counter, lap latch and wrap pulse.
  always_comb begin
    ss_p     = ss_sync_q[1] & ~ss_prev_q;
    lr_p     = lr_sync_q[1] & ~lr_prev_q;
    counting = (state_q == StRun) || (state_q == StLap);
    at_max   = (cnt_t_q == 4'(MAX_T)) && (cnt_u_q == 4'd9);

    state_d  = state_q;
    cnt_u_d  = cnt_u_q;
    cnt_t_d  = cnt_t_q;
    lap_u_d  = lap_u_q;
    lap_t_d  = lap_t_q;
    wrap_d   = 1'b0;

    // Increment is decided by the pre-edge state, independent of transitions.
    if (counting && tick) begin
      if (at_max) begin
        cnt_u_d = 4'd0;
        cnt_t_d = 4'd0;
        wrap_d  = 1'b1;
      end else if (cnt_u_q == 4'd9) begin
        cnt_u_d = 4'd0;
        cnt_t_d = cnt_t_q + 4'd1;
      end else begin
        cnt_u_d = cnt_u_q + 4'd1;
      end
    end

    // ss_p has priority over lr_p in every state.
    unique case (state_q)
      StIdle: begin
        if (ss_p) state_d = StRun;
      end
      StRun: begin
        if (ss_p) begin
          state_d = StPause;
        end else if (lr_p) begin
          state_d = StLap;
          lap_u_d = cnt_u_q;
          lap_t_d = cnt_t_q;
        end
      end
      StLap: begin
        if (ss_p)      state_d = StPause;
        else if (lr_p) state_d = StRun;
      end
      StPause: begin
        if (ss_p) begin
          state_d = StRun;
        end else if (lr_p) begin
          state_d = StIdle;
          cnt_u_d = 4'd0;
          cnt_t_d = 4'd0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state, count, lap latch and wrap registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_u_q <= 4'd0;
      cnt_t_q <= 4'd0;
      lap_u_q <= 4'd0;
      lap_t_q <= 4'd0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_u_q <= cnt_u_d;
      cnt_t_q <= cnt_t_d;
      lap_u_q <= lap_u_d;
      lap_t_q <= lap_t_d;
      wrap_q  <= wrap_d;
    end
  end

  // Display mux and state decode, all from registers.
  always_comb begin
    lap_hold = (state_q == StLap);
    running  = (state_q == StRun) || (state_q == StLap);
    disp_u   = lap_hold ? lap_u_q : cnt_u_q;
    disp_t   = lap_hold ? lap_t_q : cnt_t_q;
    wrap     = wrap_q;
  end

endmodule
